// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Divisors are handled as 32-bit values here and narrowed by the caller.
// Pure functions only, no state.
package clkdiv_pkg;

   // Smallest divisor that still gives a real high and low phase.
   localparam int unsigned DIV_MIN = 2;

   // Raise divisors of 0 or 1 to DIV_MIN so a channel never sees a degenerate period.
   function automatic logic [31:0] clamp_div(input logic [31:0] div);
      return (div < 32'(DIV_MIN)) ? 32'(DIV_MIN) : div;
   endfunction

   // Number of high cycles in one period; odd divisors get the extra cycle high.
   function automatic logic [31:0] high_time(input logic [31:0] div);
      return (div + 32'd1) >> 1;
   endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/shadow divisor, run flag, registered outputs.
// Latency: outputs reflect the counter state one clk_in cycle later (all from flops).
// No backpressure; div_load and sync are single-cycle strobes consumed immediately.
module clkdiv_channel
   import clkdiv_pkg::*;
#(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 3
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             en,
   input  logic [DIV_W-1:0] div_in,
   input  logic             div_load,
   input  logic             sync,
   output logic             clk_out,
   output logic             tick,
   output logic             div_pending
);

   localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(clamp_div(32'(DEFAULT_DIV)));

   logic             running_q, running_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] shadow_q, shadow_d;
   logic             pend_q, pend_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             wrap;
   logic             boundary;

   // Next-state: sync beats wrap beats idle-start beats normal counting; a load
   // always lands in the shadow so it only takes effect at a later boundary.
   always_comb begin
      running_d = running_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      shadow_d  = shadow_q;
      pend_d    = pend_q;
      wrap      = running_q && (cnt_q == (div_q - DIV_W'(1)));
      boundary  = 1'b0;

      if (sync && (running_q || en)) begin
         boundary  = 1'b1;
         running_d = 1'b1;
      end else if (wrap) begin
         // A disabled channel stops only here, so the current period always completes.
         boundary  = 1'b1;
         running_d = en;
      end else if (!running_q && en) begin
         boundary  = 1'b1;
         running_d = 1'b1;
      end

      if (boundary) begin
         cnt_d = '0;
         if (pend_q) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
         end
      end else if (running_q) begin
         cnt_d = cnt_q + DIV_W'(1);
      end

      if (div_load) begin
         shadow_d = DIV_W'(clamp_div(32'(div_in)));
         pend_d   = 1'b1;
      end

      // Outputs are decoded from the current counter and registered, so they
      // trail the counter by one cycle and never glitch.
      clk_out_d = running_q && (32'(cnt_q) < high_time(32'(div_q)));
      tick_d    = running_q && (cnt_q == '0);
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         running_q <= 1'b0;
         cnt_q     <= '0;
         div_q     <= RESET_DIV;
         shadow_q  <= RESET_DIV;
         pend_q    <= 1'b0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         running_q <= running_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         shadow_q  <= shadow_d;
         pend_q    <= pend_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
      end
   end

   assign clk_out     = clk_out_q;
   assign tick        = tick_q;
   assign div_pending = pend_q;

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH independent programmable clock dividers with tick strobes and global phase sync.
// Latency: enable or sync sampled at edge k gives first high/tick after edge k+1.
// No backpressure; all control inputs are strobes or levels sampled every cycle.
module clock_divider_multi #(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 3
) (
   input  logic                    clk_in,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH*DIV_W-1:0] div_in,
   input  logic [NUM_CH-1:0]       div_load,
   input  logic                    sync,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       div_pending
);

   // One channel per output bit; sync is shared so running channels realign together.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      clkdiv_channel #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_in      (clk_in),
         .rst_n       (reset),
         .en          (en[c]),
         .div_in      (div_in[c*DIV_W +: DIV_W]),
         .div_load    (div_load[c]),
         .sync        (sync),
         .clk_out     (clk_out[c]),
         .tick        (tick[c]),
         .div_pending (div_pending[c])
      );
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
module tb_clock_divider_multi;

   logic        clk_in = 1'b0;
   logic        reset;
   logic [3:0]  en;
   logic [31:0] div_in;
   logic [3:0]  div_load;
   logic        sync;
   logic [3:0]  clk_out;
   logic [3:0]  tick;
   logic [3:0]  div_pending;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit          rst;
      logic [3:0]  en;
      logic [3:0]  load;
      logic [31:0] div;
      int          ch;
      logic        e_clk;
      logic        e_tick;
      logic        e_pend;
   } vec_t;

   vec_t tbl[$];

   clock_divider_multi #(
      .NUM_CH      (4),
      .DIV_W       (8),
      .DEFAULT_DIV (3)
   ) dut (
      .clk_in      (clk_in),
      .reset       (reset),
      .en          (en),
      .div_in      (div_in),
      .div_load    (div_load),
      .sync        (sync),
      .clk_out     (clk_out),
      .tick        (tick),
      .div_pending (div_pending)
   );

   always #42 clk_in = ~clk_in;

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input bit rst, input logic [3:0] e, input logic [3:0] ld,
                          input logic [31:0] dv, input int ch,
                          input logic c, input logic t, input logic p);
      vec_t v;
      v.rst = rst; v.en = e; v.load = ld; v.div = dv; v.ch = ch;
      v.e_clk = c; v.e_tick = t; v.e_pend = p;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      en       = '0;
      div_load = '0;
      div_in   = '0;
      sync     = 1'b0;
      step();
      reset    = 1'b1;
   endtask

   initial begin
      logic [3:0] s_clk [6];
      logic [3:0] s_tick[6];
      logic       r_c[6];
      logic       r_t[6];
      logic       p_c[4];
      logic       p_t[4];
      int         highs;
      int         ticks;
      int         stray;

      s_clk  = '{4'b0111, 4'b0111, 4'b0100, 4'b0001, 4'b0011, 4'b0110};
      s_tick = '{4'b0111, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100};
      r_c    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      r_t    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      p_c    = '{1'b1, 1'b1, 1'b0, 1'b1};
      p_t    = '{1'b1, 1'b0, 1'b0, 1'b1};

      // Channel 0, default divisor 3: first tick one cycle after start, then 1,1,0.
      add_vec(0, 4'b0001, 4'b0000, 32'h0, 0, 0, 0, 0);
      add_vec(0, 4'b0001, 4'b0000, 32'h0, 0, 1, 1, 0);
      add_vec(0, 4'b0001, 4'b0000, 32'h0, 0, 1, 0, 0);
      add_vec(0, 4'b0001, 4'b0000, 32'h0, 0, 0, 0, 0);
      add_vec(0, 4'b0001, 4'b0000, 32'h0, 0, 1, 1, 0);
      add_vec(0, 4'b0001, 4'b0000, 32'h0, 0, 1, 0, 0);
      add_vec(0, 4'b0001, 4'b0000, 32'h0, 0, 0, 0, 0);
      add_vec(0, 4'b0001, 4'b0000, 32'h0, 0, 1, 1, 0);
      // Channel 1: load 4 mid-period, old period finishes, then 1,1,0,0.
      add_vec(1, 4'b0010, 4'b0000, 32'h0,      1, 0, 0, 0);
      add_vec(0, 4'b0010, 4'b0000, 32'h0,      1, 1, 1, 0);
      add_vec(0, 4'b0010, 4'b0010, 32'h0400,   1, 1, 0, 1);
      add_vec(0, 4'b0010, 4'b0000, 32'h0,      1, 0, 0, 0);
      add_vec(0, 4'b0010, 4'b0000, 32'h0,      1, 1, 1, 0);
      add_vec(0, 4'b0010, 4'b0000, 32'h0,      1, 1, 0, 0);
      add_vec(0, 4'b0010, 4'b0000, 32'h0,      1, 0, 0, 0);
      add_vec(0, 4'b0010, 4'b0000, 32'h0,      1, 0, 0, 0);
      add_vec(0, 4'b0010, 4'b0000, 32'h0,      1, 1, 1, 0);
      // Load 5 then overwrite with 1 (clamped to 2) before the wrap: result is 1,0.
      add_vec(0, 4'b0010, 4'b0010, 32'h0500,   1, 1, 0, 1);
      add_vec(0, 4'b0010, 4'b0010, 32'h0100,   1, 0, 0, 1);
      add_vec(0, 4'b0010, 4'b0000, 32'h0,      1, 0, 0, 0);
      add_vec(0, 4'b0010, 4'b0000, 32'h0,      1, 1, 1, 0);
      add_vec(0, 4'b0010, 4'b0000, 32'h0,      1, 0, 0, 0);
      add_vec(0, 4'b0010, 4'b0000, 32'h0,      1, 1, 1, 0);
      add_vec(0, 4'b0010, 4'b0000, 32'h0,      1, 0, 0, 0);

      // Reset state while reset is held.
      reset    = 1'b0;
      en       = '0;
      div_load = '0;
      div_in   = '0;
      sync     = 1'b0;
      step();
      step();
      chk("rst_clk_out", 32'(clk_out), 32'h0);
      chk("rst_tick", 32'(tick), 32'h0);
      chk("rst_pending", 32'(div_pending), 32'h0);
      reset = 1'b1;

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         en       = tbl[i].en;
         div_load = tbl[i].load;
         div_in   = tbl[i].div;
         step();
         chk($sformatf("tbl%0d_clk", i),  32'(clk_out[tbl[i].ch]),     32'(tbl[i].e_clk));
         chk($sformatf("tbl%0d_tick", i), 32'(tick[tbl[i].ch]),        32'(tbl[i].e_tick));
         chk($sformatf("tbl%0d_pend", i), 32'(div_pending[tbl[i].ch]), 32'(tbl[i].e_pend));
      end

      // Channel 1 continues (counter at 0, D=2): load 255, then one long period.
      div_load = 4'b0010;
      div_in   = 32'h0000_FF00;
      step();
      div_load = '0;
      div_in   = '0;
      chk("d255_pend_set", 32'(div_pending[1]), 32'h1);
      step();
      chk("d255_old_low", 32'(clk_out[1]), 32'h0);
      chk("d255_pend_clr", 32'(div_pending[1]), 32'h0);
      highs = 0;
      ticks = 0;
      for (int i = 0; i < 255; i++) begin
         div_load = (i == 10) ? 4'b0010 : 4'b0000;
         div_in   = '0;
         step();
         if (clk_out[1]) highs++;
         if (tick[1]) ticks++;
         if (i == 10) chk("d255_pend_mid", 32'(div_pending[1]), 32'h1);
      end
      div_load = '0;
      chk("d255_high_cycles", 32'(highs), 32'd128);
      chk("d255_ticks", 32'(ticks), 32'd1);
      step();
      chk("d0_clk_a", 32'(clk_out[1]), 32'h1);
      chk("d0_tick_a", 32'(tick[1]), 32'h1);
      chk("d0_pend", 32'(div_pending[1]), 32'h0);
      step();
      chk("d0_clk_b", 32'(clk_out[1]), 32'h0);
      step();
      chk("d0_tick_c", 32'(tick[1]), 32'h1);

      // Sync: channels at D=3,4,5 started out of phase, then realigned.
      do_reset();
      div_in   = 32'h0005_0403;
      div_load = 4'b0111;
      step();
      div_load = '0;
      chk("sync_idle_pend", 32'(div_pending), 32'h7);
      en = 4'b0001; step();
      en = 4'b0011; step();
      en = 4'b0111; step();
      chk("sync_start_pend", 32'(div_pending), 32'h0);
      step();
      step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("sync%0d_clk", i),  32'(clk_out), 32'(s_clk[i]));
         chk($sformatf("sync%0d_tick", i), 32'(tick),    32'(s_tick[i]));
      end

      // Disable mid-high: period completes, then silence, then restart.
      do_reset();
      en = 4'b0001;
      step();
      step();
      chk("dis_high", 32'(clk_out[0]), 32'h1);
      en = 4'b0000;
      step();
      chk("dis_finish_clk", 32'(clk_out[0]), 32'h1);
      chk("dis_finish_tick", 32'(tick[0]), 32'h0);
      step();
      chk("dis_last_low", 32'(clk_out[0]), 32'h0);
      stray = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (clk_out[0] || tick[0]) stray++;
      end
      chk("dis_quiet", 32'(stray), 32'h0);
      en = 4'b0001;
      step();
      chk("reen_wait", 32'(clk_out[0]), 32'h0);
      step();
      chk("reen_clk", 32'(clk_out[0]), 32'h1);
      chk("reen_tick", 32'(tick[0]), 32'h1);

      // Async reset mid-high with D=5 loaded; divisor returns to 3 afterwards.
      do_reset();
      div_in   = 32'h0000_0005;
      div_load = 4'b0001;
      step();
      div_load = '0;
      chk("rs_pend", 32'(div_pending[0]), 32'h1);
      en = 4'b0001;
      step();
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("rs_d5_clk%0d", i),  32'(clk_out[0]), 32'(r_c[i]));
         chk($sformatf("rs_d5_tick%0d", i), 32'(tick[0]),    32'(r_t[i]));
      end
      #10;
      reset = 1'b0;
      #1;
      chk("rs_async_clk", 32'(clk_out), 32'h0);
      chk("rs_async_tick", 32'(tick), 32'h0);
      chk("rs_async_pend", 32'(div_pending), 32'h0);
      #5;
      reset = 1'b1;
      step();
      chk("rs_post_idle", 32'(clk_out[0]), 32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("rs_d3_clk%0d", i),  32'(clk_out[0]), 32'(p_c[i]));
         chk($sformatf("rs_d3_tick%0d", i), 32'(tick[0]),    32'(p_t[i]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clock_divider_multi.md
# clock_divider_multi

Multi-channel programmable clock-enable and divided-clock generator, clocked from the board oscillator. It generalises the fixed 12 MHz → 4 MHz divider in several ways:
- NUM_CH independent channels.
- Runtime divisor per channel, updated glitch-free at period boundaries.
- Per-channel enable.
- Global phase-sync input.

Each channel outputs a registered divided clock plus a one-cycle tick strobe for downstream logic that runs on clk_in with clock enables.

## Interface

Parameters
- NUM_CH, 4, number of independent channels
- DIV_W, 8, divisor width; max divisor 2^DIV_W-1
- DEFAULT_DIV, 3, divisor loaded into every channel at reset (12 MHz → 4 MHz)

Ports
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk_in  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- en  input  NUM_CH  per-channel run enable
- div_in  input  NUM_CH*DIV_W  divisor values; channel c uses bits [c*DIV_W +: DIV_W]
- div_load  input  NUM_CH  one-cycle strobe: capture div_in slice for channel c
- sync  input  1  one-cycle strobe: restart all running channels in phase
- clk_out  output  NUM_CH  divided clock, registered
- tick  output  NUM_CH  one-cycle pulse coincident with each clk_out rising cycle
- div_pending  output  NUM_CH  shadow divisor captured, not yet applied

## Operation
- Per-channel state:
  - running flag
  - counter cnt, 0..D-1
  - active divisor D
  - shadow divisor S plus pending flag
- Clamping: divisor values below 2 are clamped to 2, on capture. D=0/1 never occur.
- High time: H = (D+1)>>1. clk_out is 1 while cnt < H and running, 0 otherwise.
- Period: exactly D clk_in cycles. High for H cycles, low for D-H.
- tick=1 exactly in the cycles where cnt==0 and running.
- Wrap point (cnt==D-1):
  - If pending, D←S and pending clears.
  - If en==0, the channel stops: running=0, clk_out stays 0.
  - Otherwise cnt←0.
- Idle channel with en==1: starts next cycle with cnt=0. Any pending divisor is applied first.
- Disable is never abrupt: deasserting en mid-period lets the current period finish.
- div_load:
  - S←clamp(slice), pending=1.
  - A repeated load before application overwrites S.
  - Loads on an idle channel apply at start.
- sync:
  - Every channel with running=1 or en=1 gets cnt←0 next cycle, with pending divisors applied.
  - Channels with en==0 and idle are unaffected.
- Priorities: sync over wrap over normal count. div_load coincident with a wrap or sync is captured as pending for the following boundary. It is not applied in the same cycle.

## Timing
- Reset (asynchronous, immediate):
  - clk_out=0, tick=0, div_pending=0
  - cnt=0, running=0
  - D=clamp(DEFAULT_DIV)
- Deassertion is used synchronously by the next clk_in edge.
- en sampled high at edge k on an idle channel: clk_out=1 and tick=1 after edge k+1.
- sync sampled at edge k: all affected clk_out=1 and tick=1 after edge k+1, i.e. aligned.
- New divisor takes effect on the first period that begins after capture. The period in progress keeps its old length.
- No output glitches: all outputs come straight from flops.

## Structure
- Package clkdiv_pkg:
  - DIV_MIN=2
  - function clamp_div
  - function high_time(D) = (D+1)>>1
- Sub-module clkdiv_channel holds one channel's state (cnt, D, S, pending, running) and its outputs. It is instantiated NUM_CH times in a generate loop. sync fans out to every instance.
- Top level contains only slicing and the generate loop.

## Test plan
- Reset, then en[0]=1 with DEFAULT_DIV=3 → clk_out[0] = 1,1,0 repeating, tick[0] every 3 cycles, first tick 1 cycle after en. 83.3 ns clk_in gives a 250 ns period.
- Ch1 running at D=3, div_load=4 mid-period → current period still 3 cycles, div_pending=1 until the wrap, then pattern 1,1,0,0.
- Loads of 0 and 1 → pattern 1,0 (D=2). Load of 255 → period 255, high 128 cycles.
- Channels at D=3,4,5, mutually out of phase, pulse sync → all tick and clk_out rise in the same cycle. Ch2 follows 1,1,1,0,0.
- en[0] dropped while clk_out[0] high → period completes, then clk_out stays 0 and no further ticks. Re-enable → restart after 1 cycle.
- reset asserted mid-high, asynchronously between edges → clk_out and tick go 0 immediately. After release the divisor reverts to 3, even if 5 had been loaded.
